reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Architectural register file for the 16-bit core: 16 registers, two combinational read ports, one synchronous write port.
- Consumes one-hot wordlines built from 4-bit register IDs. Write-select and read-select are one-hot decoded internally.
- Includes write-to-read bypass and R0 hardwired to zero.
- Adds a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data ports.
- ADDR_WIDTH, 4, register ID width. NUM_REGS = 2**ADDR_WIDTH = 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- SrcReg1  input  ADDR_WIDTH  read port 1 register ID.
- SrcReg2  input  ADDR_WIDTH  read port 2 register ID.
- SrcData1  output  DATA_WIDTH  read port 1 data (combinational).
- SrcData2  output  DATA_WIDTH  read port 2 data (combinational).
- DstReg  input  ADDR_WIDTH  write-back register ID.
- WriteReg  input  1  write enable.
- DstData  input  DATA_WIDTH  write-back data.
- IssueValid  input  1  an instruction writing IssueReg is issued this cycle.
- IssueReg  input  ADDR_WIDTH  destination ID of the issuing instruction.
- Hazard1  output  1  SrcReg1 has an outstanding producer.
- Hazard2  output  1  SrcReg2 has an outstanding producer.
- BusyVec  output  NUM_REGS  registered scoreboard; bit i = register i busy.

Behaviour:
- Reset: on a rising edge with rst=1, all registers clear to 0 and BusyVec clears to 0.
  - While rst=1: SrcData1/2 are forced to 0, Hazard1/2 are forced to 0, and writes and issues are ignored.
  - rst overrides every other input on the same edge.
  - A reset asserted mid-sequence discards all pending busy bits.
- Write:
  - Takes effect when WriteReg=1 and DstReg!=0: reg[DstReg] <= DstData on the rising edge.
  - Writes to R0 are dropped. DstReg is one-hot decoded to a 16-bit write wordline; exactly one bit is set when enabled, none otherwise.
- Read:
  - SrcDataN = 0 if SrcRegN==0.
  - Else SrcDataN = DstData if WriteReg=1 and DstReg==SrcRegN (same-cycle bypass).
  - Else SrcDataN = reg[SrcRegN].
  - Zero-cycle latency. Both ports are independent and may address the same register.
- Scoreboard, evaluated per bit i on each edge:
  - set_i = IssueValid && IssueReg==i && i!=0.
  - clr_i = WriteReg && DstReg==i.
  - busy[i] <= set_i ? 1 : (clr_i ? 0 : busy[i]). Set wins over clear on the same register in the same cycle, since the new producer supersedes the old one.
  - busy[0] is always 0.
  - Issuing to an already-busy register keeps it busy. There is no count; a single write-back clears the bit.
  - Write-back to a non-busy register is legal: data is written and the bit stays 0.
- Hazard:
  - HazardN = busy[SrcRegN] && !(WriteReg && DstReg==SrcRegN) && SrcRegN!=0.
  - A write-back landing this cycle resolves the hazard, and bypass supplies the data.
  - Combinational from BusyVec and the current inputs.
- Width rules: no arithmetic is performed. IDs are unsigned. All NUM_REGS IDs are valid, so there are no out-of-range cases.

Test Plan:
- Reset then read:
  - Stimulus: rst=1 for 2 cycles; write R5=0xBEEF during reset; release reset; read SrcReg1=5.
  - Required: SrcData1=0x0000, BusyVec=0x0000.
- Write/read/bypass:
  - Stimulus: write R3=0x1234; next cycle read R3 on both ports. Then, with WriteReg=1, DstReg=3, DstData=0xABCD, read SrcReg2=3 in the same cycle.
  - Required: both ports read 0x1234 the cycle after the first write. In the bypass cycle, SrcData2=0xABCD; on the following cycle it reads stored 0xABCD.
- R0 rules:
  - Stimulus: write R0=0xFFFF; issue IssueReg=0; read SrcReg1=0.
  - Required: SrcData1=0, BusyVec[0]=0, Hazard1=0.
- Scoreboard lifecycle:
  - Stimulus: issue R7; next cycle read SrcReg1=7. Then write back R7=0x0042 while SrcReg1=7.
  - Required: after the issue, BusyVec=0x0080 and Hazard1=1. In the write-back cycle, Hazard1=0 and SrcData1=0x0042; next cycle BusyVec=0x0000.
- Set-vs-clear collision:
  - Stimulus: with R9 busy, apply IssueValid=1, IssueReg=9 and WriteReg=1, DstReg=9, DstData=0x0009 in the same cycle.
  - Required: next cycle BusyVec[9]=1 and reg9=0x0009.
- Reset mid-operation:
  - Stimulus: busy R1, R2, R15; assert rst for 1 cycle.
  - Required: BusyVec=0x0000 and all registers read 0 afterwards.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with write-to-read bypass, R0 hardwired to
// zero, and a per-register busy scoreboard for RAW hazard detection.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] SrcReg1,
    input  logic [ADDR_WIDTH-1:0] SrcReg2,
    output logic [DATA_WIDTH-1:0] SrcData1,
    output logic [DATA_WIDTH-1:0] SrcData2,
    input  logic [ADDR_WIDTH-1:0] DstReg,
    input  logic                  WriteReg,
    input  logic [DATA_WIDTH-1:0] DstData,
    input  logic                  IssueValid,
    input  logic [ADDR_WIDTH-1:0] IssueReg,
    output logic                  Hazard1,
    output logic                  Hazard2,
    output logic [NUM_REGS-1:0]   BusyVec
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic [NUM_REGS-1:0]   wr_wl;    // data write wordline, never selects R0
    logic [NUM_REGS-1:0]   clr_wl;   // write-back wordline for scoreboard clear
    logic [NUM_REGS-1:0]   iss_wl;   // issue wordline, never selects R0
    logic [NUM_REGS-1:0]   rd1_wl;
    logic [NUM_REGS-1:0]   rd2_wl;
    logic [DATA_WIDTH-1:0] rd1_raw;
    logic [DATA_WIDTH-1:0] rd2_raw;
    logic                  byp1;
    logic                  byp2;

    // One-hot decode of every register ID into its wordline
    always_comb begin
        wr_wl  = '0;
        clr_wl = '0;
        iss_wl = '0;
        rd1_wl = '0;
        rd2_wl = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            clr_wl[i] = WriteReg && (DstReg == ADDR_WIDTH'(i));
            wr_wl[i]  = clr_wl[i] && (i != 0);
            iss_wl[i] = IssueValid && (IssueReg == ADDR_WIDTH'(i)) && (i != 0);
            rd1_wl[i] = (SrcReg1 == ADDR_WIDTH'(i));
            rd2_wl[i] = (SrcReg2 == ADDR_WIDTH'(i));
        end
    end

    // Register storage: synchronous clear on reset, wordline-gated writes
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else if (wr_wl[i]) begin
                regs_q[i] <= DstData;
            end
        end
    end

    // Scoreboard next state: issue wins over write-back on the same register
    always_comb begin
        busy_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_d[i] = iss_wl[i] | (~clr_wl[i] & busy_q[i]);
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // AND-OR read mux driven by the one-hot read wordlines
    always_comb begin
        rd1_raw = '0;
        rd2_raw = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rd1_raw = rd1_raw | (rd1_wl[i] ? regs_q[i] : '0);
            rd2_raw = rd2_raw | (rd2_wl[i] ? regs_q[i] : '0);
        end
    end

    // Read ports with R0 forcing, same-cycle bypass and hazard detection
    always_comb begin
        byp1 = WriteReg && (DstReg == SrcReg1);
        byp2 = WriteReg && (DstReg == SrcReg2);

        if (rst || SrcReg1 == '0) begin
            SrcData1 = '0;
        end else if (byp1) begin
            SrcData1 = DstData;
        end else begin
            SrcData1 = rd1_raw;
        end

        if (rst || SrcReg2 == '0) begin
            SrcData2 = '0;
        end else if (byp2) begin
            SrcData2 = DstData;
        end else begin
            SrcData2 = rd2_raw;
        end

        Hazard1 = !rst && (|(busy_q & rd1_wl)) && !byp1 && (SrcReg1 != '0);
        Hazard2 = !rst && (|(busy_q & rd2_wl)) && !byp2 && (SrcReg2 != '0);
    end

    assign BusyVec = busy_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  SrcReg1, SrcReg2, DstReg, IssueReg;
    logic [15:0] SrcData1, SrcData2, DstData;
    logic        WriteReg, IssueValid;
    logic        Hazard1, Hazard2;
    logic [15:0] BusyVec;

    int checks   = 0;
    int failures = 0;

    reg_file_scoreboard #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SrcReg1    (SrcReg1),
        .SrcReg2    (SrcReg2),
        .SrcData1   (SrcData1),
        .SrcData2   (SrcData2),
        .DstReg     (DstReg),
        .WriteReg   (WriteReg),
        .DstData    (DstData),
        .IssueValid (IssueValid),
        .IssueReg   (IssueReg),
        .Hazard1    (Hazard1),
        .Hazard2    (Hazard2),
        .BusyVec    (BusyVec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WriteReg   = 1'b0;
        IssueValid = 1'b0;
        DstReg     = '0;
        IssueReg   = '0;
        DstData    = '0;
    endtask

    initial begin
        idle();
        SrcReg1 = '0;
        SrcReg2 = '0;

        // Reset with a write to R5 that must be ignored
        rst      = 1'b1;
        WriteReg = 1'b1;
        DstReg   = 4'd5;
        DstData  = 16'hBEEF;
        SrcReg1  = 4'd5;
        #1;
        check("rst_src1_forced", SrcData1, 16'h0000);
        check("rst_haz1_forced", Hazard1, 1'b0);
        tick();
        tick();
        check("rst_busy", BusyVec, 16'h0000);
        rst = 1'b0;
        idle();
        #1;
        check("post_rst_r5", SrcData1, 16'h0000);

        // Write R3, read it back on both ports
        WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h1234;
        tick();
        idle();
        SrcReg1 = 4'd3; SrcReg2 = 4'd3;
        #1;
        check("rd_r3_p1", SrcData1, 16'h1234);
        check("rd_r3_p2", SrcData2, 16'h1234);

        // Same-cycle bypass on R3
        WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'hABCD;
        #1;
        check("bypass_p2", SrcData2, 16'hABCD);
        check("bypass_p1", SrcData1, 16'hABCD);
        tick();
        idle();
        #1;
        check("stored_abcd", SrcData2, 16'hABCD);

        // R0 write / issue / read rules
        WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'hFFFF;
        IssueValid = 1'b1; IssueReg = 4'd0;
        SrcReg1 = 4'd0;
        #1;
        check("r0_read_bypass", SrcData1, 16'h0000);
        check("r0_haz", Hazard1, 1'b0);
        tick();
        idle();
        #1;
        check("r0_busy", BusyVec, 16'h0000);
        check("r0_read", SrcData1, 16'h0000);

        // Scoreboard lifecycle on R7
        IssueValid = 1'b1; IssueReg = 4'd7; SrcReg1 = 4'd7;
        #1;
        check("issue_cycle_haz", Hazard1, 1'b0);
        tick();
        idle();
        #1;
        check("r7_busy", BusyVec, 16'h0080);
        check("r7_haz", Hazard1, 1'b1);
        WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h0042;
        #1;
        check("wb_haz_resolved", Hazard1, 1'b0);
        check("wb_bypass", SrcData1, 16'h0042);
        tick();
        idle();
        #1;
        check("r7_cleared", BusyVec, 16'h0000);
        check("r7_stored", SrcData1, 16'h0042);
        check("r7_haz_gone", Hazard1, 1'b0);

        // Set-vs-clear collision on R9
        IssueValid = 1'b1; IssueReg = 4'd9;
        tick();
        idle();
        #1;
        check("r9_busy", BusyVec, 16'h0200);
        IssueValid = 1'b1; IssueReg = 4'd9;
        WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h0009;
        SrcReg2 = 4'd9;
        #1;
        check("collide_haz2", Hazard2, 1'b0);
        tick();
        idle();
        #1;
        check("collide_busy", BusyVec, 16'h0200);
        check("collide_data", SrcData2, 16'h0009);
        check("collide_haz2_after", Hazard2, 1'b1);

        // Write-back to a non-busy register leaves the scoreboard alone
        WriteReg = 1'b1; DstReg = 4'd4; DstData = 16'h5555;
        tick();
        idle();
        SrcReg1 = 4'd4;
        #1;
        check("nonbusy_wb_busy", BusyVec, 16'h0200);
        check("nonbusy_wb_data", SrcData1, 16'h5555);

        // Issue and unrelated write-back in the same cycle
        IssueValid = 1'b1; IssueReg = 4'd1;
        WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h0099;
        tick();
        idle();
        #1;
        check("iss1_wb9_busy", BusyVec, 16'h0002);

        // Build up busy R1, R2, R15 (R1 reissued, stays busy), then reset
        IssueValid = 1'b1; IssueReg = 4'd2;
        tick();
        IssueReg = 4'd15;
        tick();
        IssueReg = 4'd1;
        tick();
        idle();
        SrcReg1 = 4'd15; SrcReg2 = 4'd2;
        #1;
        check("multi_busy", BusyVec, 16'h8006);
        check("haz1_r15", Hazard1, 1'b1);
        check("haz2_r2", Hazard2, 1'b1);
        rst = 1'b1;
        SrcReg1 = 4'd3;
        #1;
        check("rst_mid_haz2", Hazard2, 1'b0);
        check("rst_mid_src1", SrcData1, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_busy", BusyVec, 16'h0000);
        for (int r = 0; r < 16; r++) begin
            SrcReg1 = 4'(r);
            #1;
            check($sformatf("rst_mid_r%0d", r), SrcData1, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
